// File: rtl/mul_res_stage.sv
// Result-select stage for the FP multiplier: NaN/inf/overflow/normal pick,
// 2-entry skid buffer on the output, and sticky exception flags.
module mul_res_stage #(
    parameter int EXPO_W    = 8,
    parameter int MANT_W    = 23,
    parameter bit CANON_NAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_nan,
    input  logic              is_inf,
    input  logic              nan_sign,
    input  logic [MANT_W-1:0] nan_mant,
    input  logic              overflow,
    input  logic              inexact,
    input  logic              invalid,
    input  logic [2:0]        rm,
    input  logic              sign,
    input  logic [EXPO_W-1:0] expo,
    input  logic [MANT_W-1:0] mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              res_sign,
    output logic [EXPO_W-1:0] res_expo,
    output logic [MANT_W-1:0] res_mant,
    output logic [2:0]        res_flags,
    input  logic              flags_clr,
    output logic [2:0]        fflags
);

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;

    localparam logic [EXPO_W-1:0] EXPO_ONES = {EXPO_W{1'b1}};
    localparam logic [EXPO_W-1:0] EXPO_MAXF = {{(EXPO_W-1){1'b1}}, 1'b0};
    localparam logic [MANT_W-1:0] MANT_ONES = {MANT_W{1'b1}};
    localparam logic [MANT_W-1:0] MANT_QNAN = {1'b1, {(MANT_W-1){1'b0}}};

    typedef struct packed {
        logic              sign;
        logic [EXPO_W-1:0] expo;
        logic [MANT_W-1:0] mant;
        logic [2:0]        flags;
    } beat_t;

    beat_t in_beat;
    logic  ovf_to_inf;
    logic  special;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic [2:0] fflags_q, fflags_d;

    logic accept;
    logic drain;

    // Overflow rounds to infinity unless the mode rounds toward zero here
    always_comb begin
        case (rm)
            RM_RTZ:  ovf_to_inf = 1'b0;
            RM_RDN:  ovf_to_inf = sign;
            RM_RUP:  ovf_to_inf = !sign;
            default: ovf_to_inf = 1'b1;
        endcase
    end

    assign special = is_nan || is_inf;

    always_comb begin
        in_beat.sign  = sign;
        in_beat.expo  = expo;
        in_beat.mant  = mant;
        in_beat.flags = {invalid,
                         overflow && !special,
                         (inexact || overflow) && !special};
        if (is_nan) begin
            in_beat.expo = EXPO_ONES;
            if (CANON_NAN) begin
                in_beat.sign = 1'b0;
                in_beat.mant = MANT_QNAN;
            end else begin
                in_beat.sign = nan_sign;
                in_beat.mant = nan_mant;
            end
        end else if (is_inf) begin
            in_beat.expo = EXPO_ONES;
            in_beat.mant = '0;
        end else if (overflow) begin
            in_beat.expo = ovf_to_inf ? EXPO_ONES : EXPO_MAXF;
            in_beat.mant = ovf_to_inf ? '0 : MANT_ONES;
        end
    end

    assign accept = in_valid && !skid_valid_q;
    assign drain  = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            main_valid_d = skid_valid_q;
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
                main_d = skid_q;
            end
        end
        // accept implies skid empty, so a draining main is free for the new beat
        if (accept) begin
            if (!main_valid_q || drain) begin
                main_d       = in_beat;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        fflags_d = fflags_q;
        if (drain) begin
            fflags_d = (flags_clr ? 3'b000 : fflags_q) | main_q.flags;
        end else if (flags_clr) begin
            fflags_d = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            fflags_q     <= 3'b000;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            fflags_q     <= fflags_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign res_sign  = main_q.sign;
    assign res_expo  = main_q.expo;
    assign res_mant  = main_q.mant;
    assign res_flags = main_q.flags;
    assign fflags    = fflags_q;

endmodule
